sh7604_ibus_initiator: RTL and testbench
========================================

Name: sh7604_ibus_initiator

Overview:
- Single-outstanding IBUS master for the SH7604 on-chip bus. It is the requesting side of the protocol that the on-chip peripherals (DIVU, DMAC regs, FRT, …) respond to.
- Accepts byte/word/long read and write commands from an internal client (DMA engine, debug port).
- Drives IBUS address, data, byte lanes and request; honours slave BUSY stalls; returns read data aligned to bit 0.
- Flags misaligned or unclaimed (no ACT) accesses as errors.

Parameters:
TIMEOUT_CYC, 16, CE_R cycles with REQ high and ACT low before the access is aborted with error (range 2..255)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CE_R  in  1  rising-phase clock enable
CE_F  in  1  falling-phase clock enable
EN  in  1  block enable; when 0, state and outputs hold
RES_N  in  1  soft reset, synchronous, sampled on CE_R
CMD_VALID  in  1  command present
CMD_READY  out  1  command accepted when VALID&READY on a CE_R cycle
CMD_ADDR  in  32  byte address
CMD_WDATA  in  32  write data, right-aligned
CMD_SIZE  in  2  0=byte, 1=word, 2=long, 3=reserved (error)
CMD_WE  in  1  1=write
RSP_VALID  out  1  one-CLK pulse on completion
RSP_RDATA  out  32  read data, zero-extended; 0 for writes and errors
RSP_ERR  out  1  valid with RSP_VALID
IBUS_A  out  32  bus address
IBUS_DO  out  32  write data to slave (lane-replicated)
IBUS_DI  in  32  read data from slave
IBUS_BA  out  4  byte-lane enables
IBUS_WE  out  1  write strobe
IBUS_REQ  out  1  request
IBUS_BUSY  in  1  slave stall
IBUS_ACT  in  1  address claimed by a slave

Behaviour:
- Reset (RST_N low, or RES_N low on CE_R):
  - State goes to IDLE.
  - CMD_READY=1; RSP_VALID=0; RSP_ERR=0; RSP_RDATA=0.
  - IBUS_A, IBUS_DO and IBUS_BA are 0; IBUS_WE=0; IBUS_REQ=0.
  - RES_N mid-access drops REQ immediately and produces no response.
- State advance: state moves only when EN=1, on the enabled edge named below.
- IDLE:
  - CMD_READY=1.
  - On CE_R with CMD_VALID: latch the command and set CMD_READY=0.
  - If misaligned (word with A[0]=1, long with A[1:0]≠0, or SIZE=3): go to RESP with ERR=1; no bus cycle is issued.
  - Otherwise drive IBUS_A/WE/BA/DO and REQ=1, then go to ADDR.
- Byte lanes:
  - Byte: BA = 4'b1000 >> A[1:0].
  - Word: BA = A[1] ? 4'b0011 : 4'b1100.
  - Long: BA = 4'b1111.
- Write data: byte → {4{WDATA[7:0]}}; word → {2{WDATA[15:0]}}; long → WDATA.
- ADDR: on the next CE_F go to WAIT. This guarantees the slave has registered read data.
- WAIT, evaluated on each CE_R:
  - ACT=1 and BUSY=0: capture data, deassert REQ, go to RESP.
  - ACT=1 and BUSY=1: stay (stall). No timeout while ACT=1.
  - ACT=0: increment the timeout counter. At TIMEOUT_CYC, deassert REQ and go to RESP with ERR=1, RDATA=0.
  - The counter resets on entry to ADDR.
- Read extraction from IBUS_DI:
  - Byte: lane A[1:0], with lane 0 = bits 31:24.
  - Word: A[1] ? DI[15:0] : DI[31:16].
  - Long: DI.
  - The result is zero-extended.
- RESP: RSP_VALID=1 for exactly one CLK. Return to IDLE on the next CE_R.
- Data stability: RSP_RDATA/RSP_ERR hold their value until the next response.
- Bus signal stability: IBUS_A/DO/BA/WE stay stable from REQ rise until REQ fall. They are not required to clear afterwards.
- Latency: minimum command-to-RSP_VALID is one CE_R + one CE_F + one CE_R.

Optional Feature:
- Macro: SH7604_IBUS_INIT_STATS_EN.
- When defined, adds outputs STAT_XFER[15:0] and STAT_STALL[15:0].
  - STAT_XFER counts completed non-error accesses.
  - STAT_STALL counts CE_R cycles spent in WAIT with BUSY=1.
  - Both saturate at 16'hFFFF and clear on RST_N/RES_N.
- When not defined, the ports and counters do not exist.

Test Plan:
- Long write FFFFFF00←00000003, then long write FFFFFF04←00000064 (DIVU model) → each gives RSP_VALID, ERR=0, BA=1111, REQ high for ≥1 CE_F.
- Immediately long read FFFFFF14 while the divider runs → BUSY stall of several CE_R cycles; RSP_RDATA=00000021, ERR=0; REQ stays high throughout the stall.
- Word read FFFFFF16 with slave DO=0021_0021 → RDATA=00000021. Byte write FFFFFF0F←A5 → BA=0001, IBUS_DO=A5A5A5A5.
- Word read at 00000001 → ERR=1, RDATA=0, IBUS_REQ never asserted.
- Long read at unmapped address (ACT=0), TIMEOUT_CYC=16 → REQ drops after 16 CE_R cycles; ERR=1, RDATA=0.
- RES_N low during a BUSY stall → REQ=0 next CE_R, no RSP_VALID, CMD_READY=1. With stats enabled, STAT_XFER counts exactly 3 after the first three scenarios.

Source files
------------

// File: rtl/sh7604_ibus_initiator.sv
// Single-outstanding IBUS master: accepts client byte/word/long commands and runs one bus access each.
// Optional statistics outputs are built when SH7604_IBUS_INIT_STATS_EN is defined.
module sh7604_ibus_initiator #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        EN,
    input  logic        RES_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    input  logic [1:0]  CMD_SIZE,
    input  logic        CMD_WE,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
`ifdef SH7604_IBUS_INIT_STATS_EN
    ,
    output logic [15:0] STAT_XFER,
    output logic [15:0] STAT_STALL
`endif
);

    // state | meaning
    // IDLE  | ready for a command
    // ADDR  | REQ driven, waiting one CE_F so the slave registers read data
    // WAIT  | sampling ACT/BUSY on each CE_R, timeout runs while ACT=0
    // RESP  | response issued, back to IDLE on next CE_R
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, do_q, do_d, rdata_q, rdata_d;
    logic [3:0]  ba_q, ba_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d, req_q, req_d, err_q, err_d, vld_q, vld_d;
    logic [7:0]  tmo_q, tmo_d, tmo_nx;
`ifdef SH7604_IBUS_INIT_STATS_EN
    logic [15:0] xfer_q, xfer_d, stall_q, stall_d;
`endif

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lo[0];
            2'd2:    misaligned = (lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    lanes = 4'b1000 >> lo;
            2'd1:    lanes = lo[1] ? 4'b0011 : 4'b1100;
            default: lanes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] repl(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    repl = {4{wd[7:0]}};
            2'd1:    repl = {2{wd[15:0]}};
            default: repl = wd;
        endcase
    endfunction

    // Lane 0 is the most significant byte (big-endian bus)
    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lo,
                                            input logic [31:0] di);
        case (size)
            2'd0: begin
                case (lo)
                    2'd0:    extract = {24'h0, di[31:24]};
                    2'd1:    extract = {24'h0, di[23:16]};
                    2'd2:    extract = {24'h0, di[15:8]};
                    default: extract = {24'h0, di[7:0]};
                endcase
            end
            2'd1:    extract = lo[1] ? {16'h0, di[15:0]} : {16'h0, di[31:16]};
            default: extract = di;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        do_d    = do_q;
        ba_d    = ba_q;
        we_d    = we_q;
        req_d   = req_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        tmo_d   = tmo_q;
        tmo_nx  = tmo_q + 8'd1;
`ifdef SH7604_IBUS_INIT_STATS_EN
        xfer_d  = xfer_q;
        stall_d = stall_q;
`endif
        if (CE_R && !RES_N) begin
            state_d = IDLE;
            a_d     = '0;
            do_d    = '0;
            ba_d    = '0;
            we_d    = 1'b0;
            req_d   = 1'b0;
            size_d  = '0;
            rdata_d = '0;
            err_d   = 1'b0;
            tmo_d   = '0;
`ifdef SH7604_IBUS_INIT_STATS_EN
            xfer_d  = '0;
            stall_d = '0;
`endif
        end else if (EN) begin
            case (state_q)
                IDLE: begin
                    if (CE_R && CMD_VALID) begin
                        size_d = CMD_SIZE;
                        if (misaligned(CMD_SIZE, CMD_ADDR[1:0])) begin
                            state_d = RESP;
                            vld_d   = 1'b1;
                            err_d   = 1'b1;
                            rdata_d = '0;
                        end else begin
                            a_d     = CMD_ADDR;
                            we_d    = CMD_WE;
                            ba_d    = lanes(CMD_SIZE, CMD_ADDR[1:0]);
                            do_d    = repl(CMD_SIZE, CMD_WDATA);
                            req_d   = 1'b1;
                            tmo_d   = '0;
                            state_d = ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (CE_F) state_d = WAIT;
                end
                WAIT: begin
                    if (CE_R) begin
                        if (IBUS_ACT && !IBUS_BUSY) begin
                            rdata_d = we_q ? 32'h0 : extract(size_q, a_q[1:0], IBUS_DI);
                            err_d   = 1'b0;
                            req_d   = 1'b0;
                            vld_d   = 1'b1;
                            state_d = RESP;
`ifdef SH7604_IBUS_INIT_STATS_EN
                            if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
`endif
                        end else if (!IBUS_ACT) begin
                            tmo_d = tmo_nx;
                            if (tmo_nx >= TMO_LIM) begin
                                rdata_d = '0;
                                err_d   = 1'b1;
                                req_d   = 1'b0;
                                vld_d   = 1'b1;
                                state_d = RESP;
                            end
                        end
`ifdef SH7604_IBUS_INIT_STATS_EN
                        if (IBUS_BUSY && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (CE_R) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            do_q    <= '0;
            ba_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            tmo_q   <= '0;
`ifdef SH7604_IBUS_INIT_STATS_EN
            xfer_q  <= '0;
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            do_q    <= do_d;
            ba_q    <= ba_d;
            we_q    <= we_d;
            req_q   <= req_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
`ifdef SH7604_IBUS_INIT_STATS_EN
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
`endif
        end
    end

    assign CMD_READY = (state_q == IDLE);
    assign RSP_VALID = vld_q;
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;
    assign IBUS_A    = a_q;
    assign IBUS_DO   = do_q;
    assign IBUS_BA   = ba_q;
    assign IBUS_WE   = we_q;
    assign IBUS_REQ  = req_q;
`ifdef SH7604_IBUS_INIT_STATS_EN
    assign STAT_XFER  = xfer_q;
    assign STAT_STALL = stall_q;
`endif

endmodule

// File: tb/tb_sh7604_ibus_initiator.sv
// Directed bench for sh7604_ibus_initiator with a small DIVU-like slave model.
module tb_sh7604_ibus_initiator;

    logic        clk = 1'b0, rst_n = 1'b0, ce_r = 1'b0, ce_f = 1'b0, en = 1'b1, res_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [1:0]  cmd_size = '0;
    logic        cmd_ready, rsp_valid, rsp_err, ibus_we, ibus_req;
    logic [31:0] rsp_rdata, ibus_a, ibus_do;
    logic [3:0]  ibus_ba;
    logic [31:0] ibus_di;
    logic        ibus_busy, ibus_act;
`ifdef SH7604_IBUS_INIT_STATS_EN
    logic [15:0] stat_xfer, stat_stall;
`endif

    sh7604_ibus_initiator #(.TIMEOUT_CYC(16)) dut (
        .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f), .EN(en), .RES_N(res_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_ADDR(cmd_addr),
        .CMD_WDATA(cmd_wdata), .CMD_SIZE(cmd_size), .CMD_WE(cmd_we),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .IBUS_A(ibus_a), .IBUS_DO(ibus_do), .IBUS_DI(ibus_di), .IBUS_BA(ibus_ba),
        .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req), .IBUS_BUSY(ibus_busy), .IBUS_ACT(ibus_act)
`ifdef SH7604_IBUS_INIT_STATS_EN
        , .STAT_XFER(stat_xfer), .STAT_STALL(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // CE_R and CE_F alternate on successive clock edges
    logic ph = 1'b1;
    always @(negedge clk) begin
        ce_r = ph;
        ce_f = ~ph;
        ph   = ~ph;
    end

    // DIVU-like slave decoding FFFFFF00..FFFFFF1F
    logic [31:0] divisor = 32'd1, quot = '0;
    int          busy_cnt = 0;
    logic        stall_forever = 1'b0;

    always_comb begin
        ibus_act  = 1'b0;
        ibus_busy = 1'b0;
        ibus_di   = '0;
        if (ibus_req && ibus_a[31:8] == 24'hFFFFFF && ibus_a[7:5] == 3'd0) begin
            ibus_act  = 1'b1;
            ibus_busy = (busy_cnt != 0) || stall_forever;
            if (ibus_a[7:2] == 6'h05)
                ibus_di = (ibus_ba == 4'b1111) ? quot : {2{quot[15:0]}};
        end
    end

    always @(posedge clk) begin
        if (ce_r && ibus_act && !ibus_busy && ibus_we) begin
            if (ibus_a[7:0] == 8'h00) divisor <= ibus_do;
            if (ibus_a[7:0] == 8'h04) begin
                quot     <= ibus_do / ((divisor == 0) ? 32'd1 : divisor);
                busy_cnt <= 8;
            end
        end else if (ce_r && busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] r_data, r_do;
    logic [3:0]  r_ba;
    logic        r_err, r_reqseen, r_drop, r_done;
    int          r_reqcer, r_reqcef, r_stall;

    task automatic do_cmd(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] size, input logic we);
        int k;
        r_data = 'x; r_err = 1'bx; r_do = '0; r_ba = '0;
        r_reqseen = 0; r_drop = 0; r_done = 0;
        r_reqcer = 0; r_reqcef = 0; r_stall = 0;
        cmd_addr = addr; cmd_wdata = wd; cmd_size = size; cmd_we = we; cmd_valid = 1'b1;
        k = 0;
        while (!(cmd_ready && ce_r) && k < 200) begin
            @(negedge clk); #1; k++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                r_data = rsp_rdata; r_err = rsp_err; r_done = 1;
                break;
            end
            if (ibus_req) begin
                r_reqseen = 1; r_ba = ibus_ba; r_do = ibus_do;
                if (ce_r) r_reqcer++;
                if (ce_f) r_reqcef++;
                if (ce_r && ibus_busy) r_stall++;
            end else if (r_reqseen && busy_cnt != 0) begin
                r_drop = 1;
            end
        end
        check("rsp_seen", {31'h0, r_done}, 32'h1);
    endtask

    logic rsp_seen_rst;

    initial begin
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_req",   {31'h0, ibus_req},  32'h0);
        check("rst_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_a",     ibus_a,    32'h0);
        check("rst_ba",    {28'h0, ibus_ba}, 32'h0);

        do_cmd(32'hFFFFFF00, 32'h00000003, 2'd2, 1'b1);
        check("w00_err", {31'h0, r_err}, 32'h0);
        check("w00_ba",  {28'h0, r_ba}, 32'hF);
        check("w00_cef", {31'h0, r_reqcef != 0}, 32'h1);

        do_cmd(32'hFFFFFF04, 32'h00000064, 2'd2, 1'b1);
        check("w04_err", {31'h0, r_err}, 32'h0);
        check("w04_ba",  {28'h0, r_ba}, 32'hF);
        check("w04_cef", {31'h0, r_reqcef != 0}, 32'h1);

        do_cmd(32'hFFFFFF14, 32'h0, 2'd2, 1'b0);
        check("r14_data",  r_data, 32'h00000021);
        check("r14_err",   {31'h0, r_err}, 32'h0);
        check("r14_stall", {31'h0, r_stall >= 2}, 32'h1);
        check("r14_drop",  {31'h0, r_drop}, 32'h0);
`ifdef SH7604_IBUS_INIT_STATS_EN
        check("stat_xfer", {16'h0, stat_xfer}, 32'd3);
`endif

        do_cmd(32'h00000001, 32'h0, 2'd1, 1'b0);
        check("mis_err",  {31'h0, r_err}, 32'h1);
        check("mis_data", r_data, 32'h0);
        check("mis_req",  {31'h0, r_reqseen}, 32'h0);

        do_cmd(32'hFFFF0000, 32'h0, 2'd2, 1'b0);
        check("tmo_err",  {31'h0, r_err}, 32'h1);
        check("tmo_data", r_data, 32'h0);
        check("tmo_cyc",  r_reqcer, 32'd16);

        do_cmd(32'hFFFFFF0F, 32'h000000A5, 2'd0, 1'b1);
        check("bw_err", {31'h0, r_err}, 32'h0);
        check("bw_ba",  {28'h0, r_ba}, 32'h1);
        check("bw_do",  r_do, 32'hA5A5A5A5);

        do_cmd(32'hFFFFFF16, 32'h0, 2'd1, 1'b0);
        check("wr16_data", r_data, 32'h00000021);
        check("wr16_err",  {31'h0, r_err}, 32'h0);
        repeat (6) @(negedge clk);
        #1 check("hold_data", rsp_rdata, 32'h00000021);

        // EN low: a pending command must not start a bus cycle
        en = 1'b0;
        cmd_addr = 32'hFFFFFF14; cmd_size = 2'd2; cmd_we = 1'b0; cmd_valid = 1'b1;
        repeat (6) @(negedge clk);
        #1 check("en_req", {31'h0, ibus_req}, 32'h0);
        cmd_valid = 1'b0;
        en = 1'b1;

        // Soft reset during an endless BUSY stall
        stall_forever = 1'b1;
        cmd_addr = 32'hFFFFFF14; cmd_size = 2'd2; cmd_we = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !(cmd_ready && ce_r); i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_seen_rst = 1'b0;
        for (int i = 0, s = 0; i < 100 && s < 3; i++) begin
            @(negedge clk); #1;
            if (ce_r && ibus_req && ibus_busy) s++;
            if (rsp_valid) rsp_seen_rst = 1'b1;
        end
        check("rst_stall_req", {31'h0, ibus_req}, 32'h1);
        while (!ce_r) begin
            @(negedge clk); #1;
        end
        res_n = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        check("sr_req",   {31'h0, ibus_req},  32'h0);
        check("sr_ready", {31'h0, cmd_ready}, 32'h1);
        stall_forever = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) rsp_seen_rst = 1'b1;
        end
        check("sr_norsp", {31'h0, rsp_seen_rst}, 32'h0);
        check("sr_rdata", rsp_rdata, 32'h0);
`ifdef SH7604_IBUS_INIT_STATS_EN
        check("sr_xfer", {16'h0, stat_xfer}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
